// File: rtl/mips_ctrl_pkg.sv
// Shared opcodes, ALU selects, trap causes, FSM states and the strobe bundle
// for the multi-cycle MIPS control unit.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] TRAP_NONE        = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL     = 2'b01;
    localparam logic [1:0] TRAP_MEM_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        ST_RST,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } ctrl_state_t;

    typedef struct packed {
        logic       alu_src;
        logic [1:0] alu_op;
        logic       mem_to_reg;
        logic       mem_rd;
        logic       mem_wr;
        logic       reg_wr;
        logic       pc_src;
        logic       pc_wr;
        logic       ir_wr;
        logic       instr_done;
    } ctrl_strobes_t;

    function automatic logic op_supported(input logic [5:0] op);
        logic ok;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI: ok = 1'b1;
            default:                                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational strobe decode from FSM state, latched opcode, zero and mem_ready.
// Zero latency; mem_ready only gates the SW completion pulse.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  ctrl_state_t   state,
    input  logic [5:0]    op_q,
    input  logic          zero,
    input  logic          mem_ready,
    output ctrl_strobes_t strobes
);

    always_comb begin
        strobes = '0;
        case (state)
            ST_FETCH: begin
                strobes.ir_wr = 1'b1;
                strobes.pc_wr = 1'b1;
            end
            ST_EXEC: begin
                case (op_q)
                    OP_RTYPE: strobes.alu_op = ALU_FUNCT;
                    OP_LW, OP_SW, OP_ADDI: begin
                        strobes.alu_src = 1'b1;
                        strobes.alu_op  = ALU_ADD;
                    end
                    OP_BEQ: begin
                        strobes.alu_op     = ALU_SUB;
                        strobes.pc_src     = 1'b1;
                        strobes.pc_wr      = zero;
                        strobes.instr_done = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                // Address operands held so the memory sees a stable address while waiting
                strobes.alu_src    = 1'b1;
                strobes.alu_op     = ALU_ADD;
                strobes.mem_rd     = (op_q == OP_LW);
                strobes.mem_wr     = (op_q == OP_SW);
                strobes.instr_done = (op_q == OP_SW) && mem_ready;
            end
            ST_WB: begin
                strobes.reg_wr     = 1'b1;
                strobes.instr_done = 1'b1;
                if (op_q == OP_LW) begin
                    strobes.mem_to_reg = 1'b1;
                end else if (op_q == OP_ADDI) begin
                    strobes.alu_src = 1'b1;
                    strobes.alu_op  = ALU_ADD;
                end else if (op_q == OP_RTYPE) begin
                    strobes.alu_op = ALU_FUNCT;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM with memory-ready timeout, illegal-opcode trap and retire counter.
// BEQ 3, R/ADDI 4, SW 4+waits, LW 5+waits cycles; stalls in MEM until mem_ready or timeout.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       Instruction,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             ALUSrc,
    output logic [1:0]       ALUOp,
    output logic             MemtoReg,
    output logic             MemRd,
    output logic             MemWr,
    output logic             RegWr,
    output logic             PCSrc,
    output logic             PCWr,
    output logic             IRWr,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired,
    output logic             trap,
    output logic [1:0]       trap_cause
);

    localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

    ctrl_state_t   state;
    ctrl_state_t   state_nxt;
    logic [5:0]    op_q;
    logic [7:0]    wait_cnt;
    logic          mem_expired;
    logic          trap_set;
    logic [1:0]    cause_nxt;
    ctrl_strobes_t strobes;

    // Counter would hit the limit at the end of this cycle with no completion
    assign mem_expired = !mem_ready && ((wait_cnt + 8'd1) == TIMEOUT_LIM);

    always_comb begin
        state_nxt = state;
        trap_set  = 1'b0;
        cause_nxt = TRAP_NONE;
        case (state)
            ST_RST:    state_nxt = ST_FETCH;
            ST_FETCH:  state_nxt = ST_DECODE;
            ST_DECODE: begin
                if (op_supported(Instruction)) begin
                    state_nxt = ST_EXEC;
                end else begin
                    state_nxt = ST_TRAP;
                    trap_set  = 1'b1;
                    cause_nxt = TRAP_ILLEGAL;
                end
            end
            ST_EXEC: begin
                case (op_q)
                    OP_BEQ:       state_nxt = ST_FETCH;
                    OP_LW, OP_SW: state_nxt = ST_MEM;
                    default:      state_nxt = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    if (op_q == OP_LW) begin
                        state_nxt = ST_WB;
                    end else begin
                        state_nxt = ST_FETCH;
                    end
                end else if (mem_expired) begin
                    state_nxt = ST_TRAP;
                    trap_set  = 1'b1;
                    cause_nxt = TRAP_MEM_TIMEOUT;
                end
            end
            ST_WB:   state_nxt = ST_FETCH;
            ST_TRAP: state_nxt = ST_TRAP;
            default: state_nxt = ST_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RST;
            op_q       <= '0;
            wait_cnt   <= '0;
            retired    <= '0;
            trap       <= 1'b0;
            trap_cause <= TRAP_NONE;
        end else begin
            state <= state_nxt;
            if (state == ST_DECODE) begin
                op_q <= Instruction;
            end
            if (state == ST_MEM && !mem_ready) begin
                wait_cnt <= wait_cnt + 8'd1;
            end else begin
                wait_cnt <= '0;
            end
            if (strobes.instr_done) begin
                retired <= retired + CNT_W'(1);
            end
            if (trap_set) begin
                trap       <= 1'b1;
                trap_cause <= cause_nxt;
            end
        end
    end

    mips_ctrl_decode u_decode (
        .state     (state),
        .op_q      (op_q),
        .zero      (zero),
        .mem_ready (mem_ready),
        .strobes   (strobes)
    );

    assign ALUSrc     = strobes.alu_src;
    assign ALUOp      = strobes.alu_op;
    assign MemtoReg   = strobes.mem_to_reg;
    assign MemRd      = strobes.mem_rd;
    assign MemWr      = strobes.mem_wr;
    assign RegWr      = strobes.reg_wr;
    assign PCSrc      = strobes.pc_src;
    assign PCWr       = strobes.pc_wr;
    assign IRWr       = strobes.ir_wr;
    assign instr_done = strobes.instr_done;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for the multi-cycle control unit, checked against a per-instruction cycle model.
module tb_mips_multicycle_ctrl;

    localparam int CW  = 4;
    localparam int TMO = 16;

    localparam logic [5:0] R    = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [5:0]    Instruction = '0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          ALUSrc, MemtoReg, MemRd, MemWr, RegWr, PCSrc, PCWr, IRWr, instr_done;
    logic [1:0]    ALUOp;
    logic [CW-1:0] retired;
    logic          trap;
    logic [1:0]    trap_cause;
    logic [10:0]   obs;

    int total = 0;
    int bad   = 0;
    int ret_m = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .Instruction (Instruction),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .ALUSrc      (ALUSrc),
        .ALUOp       (ALUOp),
        .MemtoReg    (MemtoReg),
        .MemRd       (MemRd),
        .MemWr       (MemWr),
        .RegWr       (RegWr),
        .PCSrc       (PCSrc),
        .PCWr        (PCWr),
        .IRWr        (IRWr),
        .instr_done  (instr_done),
        .retired     (retired),
        .trap        (trap),
        .trap_cause  (trap_cause)
    );

    // Bit order: ALUSrc, ALUOp[1:0], MemtoReg, MemRd, MemWr, RegWr, PCSrc, PCWr, IRWr, instr_done
    assign obs = {ALUSrc, ALUOp, MemtoReg, MemRd, MemWr, RegWr, PCSrc, PCWr, IRWr, instr_done};

    function automatic int instr_len(input logic [5:0] op, input int w);
        if (op == BEQ) return 3;
        if (op == R || op == ADDI) return 4;
        if (op == SW) return 4 + w;
        return 5 + w;
    endfunction

    // Expected strobes on cycle i of an instruction (0 = FETCH), w = MEM wait cycles
    function automatic logic [10:0] exp_vec(input logic [5:0] op, input int i, input int w,
                                            input logic z);
        logic [10:0] v;
        int          mem_end;
        v       = '0;
        mem_end = 3 + w;
        if (i == 0) begin
            v[2] = 1'b1;
            v[1] = 1'b1;
        end else if (i == 2 || (i == 3 && (op == R || op == ADDI))) begin
            if (op == R)        v[9:8] = 2'b10;
            else if (op == BEQ) v[9:8] = 2'b01;
            else                v[10]  = 1'b1;
            if (op == BEQ) begin
                v[3] = 1'b1;
                v[2] = z;
                v[0] = 1'b1;
            end
            if (i == 3) begin
                v[4] = 1'b1;
                v[0] = 1'b1;
            end
        end else if ((op == LW || op == SW) && i >= 3 && i <= mem_end) begin
            v[10] = 1'b1;
            v[6]  = (op == LW);
            v[5]  = (op == SW);
            v[0]  = (op == SW) && (i == mem_end);
        end else if (op == LW && i == mem_end + 1) begin
            v[7] = 1'b1;
            v[4] = 1'b1;
            v[0] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [5:0] rand_legal();
        case ($urandom_range(0, 4))
            0:       return R;
            1:       return LW;
            2:       return SW;
            3:       return BEQ;
            default: return ADDI;
        endcase
    endfunction

    task automatic run_instr(input logic [5:0] op, input logic z, input int w);
        int n;
        n = instr_len(op, w);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            Instruction = (i == 1) ? op : 6'($urandom);
            zero        = (i == 2) ? z : 1'($urandom);
            if ((op == LW || op == SW) && i >= 3 && i <= 3 + w)
                mem_ready = (i == 3 + w);
            else
                mem_ready = 1'($urandom);
            #1;
            total++;
            if (obs !== exp_vec(op, i, w, z)) begin
                bad++;
                $display("FAIL strobes op=%b cyc=%0d w=%0d got=%b want=%b", op, i, w, obs,
                         exp_vec(op, i, w, z));
            end
            total++;
            if (retired !== CW'(ret_m) || trap !== 1'b0) begin
                bad++;
                $display("FAIL inflight op=%b cyc=%0d retired=%0d trap=%b want retired=%0d trap=0",
                         op, i, retired, trap, ret_m);
            end
        end
        ret_m = (ret_m + 1) % (1 << CW);
    endtask

    task automatic check_retired(input string name);
        @(posedge clk);
        #1;
        total++;
        if (retired !== CW'(ret_m)) begin
            bad++;
            $display("FAIL %s retired got=%0d want=%0d", name, retired, ret_m);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst         = 1'b1;
        Instruction = 6'($urandom);
        mem_ready   = 1'($urandom);
        zero        = 1'($urandom);
        @(negedge clk);
        #1;
        total++;
        if (obs !== 11'd0 || retired !== '0 || trap !== 1'b0 || trap_cause !== 2'b00) begin
            bad++;
            $display("FAIL reset strobes=%b retired=%0d trap=%b cause=%b want all zero",
                     obs, retired, trap, trap_cause);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (obs !== 11'd0) begin
            bad++;
            $display("FAIL reset_release strobes=%b want 0", obs);
        end
        ret_m = 0;
    endtask

    task automatic test_rtype();
        test_reset();
        run_instr(R, 1'($urandom), 0);
        check_retired("rtype");
        run_instr(ADDI, 1'($urandom), 0);
        check_retired("addi");
    endtask

    task automatic test_lw_wait();
        run_instr(LW, 1'($urandom), 3);
        check_retired("lw_wait");
        run_instr(SW, 1'($urandom), 2);
        check_retired("sw_wait");
    endtask

    task automatic test_beq();
        run_instr(BEQ, 1'b1, 0);
        run_instr(BEQ, 1'b0, 0);
        check_retired("beq");
    endtask

    task automatic test_mem_boundary();
        run_instr(LW, 1'($urandom), TMO - 1);
        run_instr(SW, 1'($urandom), TMO - 1);
        check_retired("mem_boundary");
    endtask

    task automatic test_sw_timeout();
        test_reset();
        run_instr(ADDI, 1'($urandom), 0);
        for (int i = 0; i < 3 + TMO; i++) begin
            @(negedge clk);
            Instruction = (i == 1) ? SW : 6'($urandom);
            zero        = 1'($urandom);
            mem_ready   = (i < 3) ? 1'($urandom) : 1'b0;
            #1;
            total++;
            if (obs !== exp_vec(SW, i, TMO, 1'b0)) begin
                bad++;
                $display("FAIL sw_timeout cyc=%0d got=%b want=%b", i, obs,
                         exp_vec(SW, i, TMO, 1'b0));
            end
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            Instruction = 6'($urandom);
            zero        = 1'($urandom);
            mem_ready   = 1'($urandom);
            #1;
            total++;
            if (obs !== 11'd0 || trap !== 1'b1 || trap_cause !== 2'b10 || retired !== CW'(ret_m)) begin
                bad++;
                $display("FAIL sw_trap k=%0d strobes=%b trap=%b cause=%b retired=%0d want 0/1/10/%0d",
                         k, obs, trap, trap_cause, retired, ret_m);
            end
        end
    endtask

    task automatic test_illegal();
        logic [5:0] bad_op;
        for (int r = 0; r < 3; r++) begin
            test_reset();
            bad_op = (r == 0) ? 6'b111111 : 6'($urandom);
            if (bad_op == R || bad_op == LW || bad_op == SW || bad_op == BEQ || bad_op == ADDI)
                bad_op = 6'b111110;
            run_instr(BEQ, 1'($urandom), 0);
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                Instruction = (i == 1) ? bad_op : 6'($urandom);
                zero        = 1'($urandom);
                mem_ready   = 1'($urandom);
                #1;
                total++;
                if (i < 2) begin
                    if (obs !== exp_vec(R, i, 0, 1'b0) || trap !== 1'b0) begin
                        bad++;
                        $display("FAIL illegal_pre op=%b cyc=%0d strobes=%b trap=%b", bad_op, i,
                                 obs, trap);
                    end
                end else if (obs !== 11'd0 || trap !== 1'b1 || trap_cause !== 2'b01 ||
                             retired !== CW'(ret_m)) begin
                    bad++;
                    $display("FAIL illegal_trap op=%b cyc=%0d strobes=%b trap=%b cause=%b retired=%0d want 0/1/01/%0d",
                             bad_op, i, obs, trap, trap_cause, retired, ret_m);
                end
            end
        end
        test_reset();
        run_instr(R, 1'($urandom), 0);
        check_retired("after_trap");
    endtask

    task automatic test_wrap();
        test_reset();
        for (int i = 0; i < 17; i++) run_instr(BEQ, 1'($urandom), 0);
        check_retired("wrap");
        total++;
        if (retired !== CW'(1)) begin
            bad++;
            $display("FAIL wrap_abs retired got=%0d want=1", retired);
        end
    endtask

    task automatic test_abort();
        test_reset();
        run_instr(ADDI, 1'($urandom), 0);
        run_instr(R, 1'($urandom), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            Instruction = (i == 1) ? LW : 6'($urandom);
            zero        = 1'($urandom);
            mem_ready   = (i < 3) ? 1'($urandom) : 1'b0;
            #1;
            total++;
            if (obs !== exp_vec(LW, i, 8, 1'b0)) begin
                bad++;
                $display("FAIL abort_pre cyc=%0d got=%b want=%b", i, obs, exp_vec(LW, i, 8, 1'b0));
            end
        end
        @(negedge clk);
        rst       = 1'b1;
        mem_ready = 1'b0;
        #1;
        total++;
        if (MemRd !== 1'b1 || retired !== CW'(ret_m)) begin
            bad++;
            $display("FAIL abort_rst_cycle MemRd=%b retired=%0d want 1/%0d", MemRd, retired, ret_m);
        end
        @(negedge clk);
        #1;
        total++;
        if (obs !== 11'd0 || retired !== '0 || trap !== 1'b0) begin
            bad++;
            $display("FAIL abort_after strobes=%b retired=%0d trap=%b want 0/0/0", obs, retired, trap);
        end
        rst   = 1'b0;
        ret_m = 0;
        run_instr(LW, 1'($urandom), 1);
        check_retired("abort_restart");
    endtask

    task automatic test_back_to_back();
        test_reset();
        for (int n = 0; n < 40; n++) begin
            run_instr(rand_legal(), 1'($urandom), $urandom_range(0, 4));
        end
        check_retired("back_to_back");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_beq();
        test_mem_boundary();
        test_sw_timeout();
        test_illegal();
        test_wrap();
        test_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
